// File: rtl/pipeline_if_stage.sv
// pipeline_if_stage: RV64 fetch stage with credit-limited imem requests and a 2-entry output queue.
// Defining IF_PERF_CNT_EN adds the perf_fetch_cnt / perf_drop_cnt counters.
module pipeline_if_stage #(
    parameter logic [63:0] RESET_PC = 64'h0000_0000_0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [63:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    input  logic        stall_ID,
    output logic        valid_ID,
    output logic [31:0] instruction_ID,
    output logic [63:0] pc_ID
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0] perf_fetch_cnt,
    output logic [31:0] perf_drop_cnt
`endif
);
    logic [63:0] pc;
    logic [1:0]  outstanding, drop_cnt, q_cnt;
    logic [63:0] fl_pc [2];
    logic        fl_wr, fl_rd;
    logic [63:0] q_pc [2];
    logic [31:0] q_inst [2];
    logic        q_head, q_tail;
    logic        deq, fire, resp_ok, drop, enq;
    logic [2:0]  credit;

    always_comb begin
        deq            = valid_ID && !stall_ID;
        credit         = {1'b0, outstanding} + {1'b0, q_cnt} - {2'b0, deq};
        imem_req_valid = !redirect_valid && credit < 3'd2;
        fire           = imem_req_valid && imem_req_ready;
        resp_ok        = imem_resp_valid && outstanding != 2'd0;
        drop           = resp_ok && (redirect_valid || drop_cnt != 2'd0);
        enq            = resp_ok && !drop;
        valid_ID       = q_cnt != 2'd0;
        instruction_ID = valid_ID ? q_inst[q_head] : NOP_INST;
        pc_ID          = valid_ID ? q_pc[q_head] : 64'd0;
        imem_req_addr  = pc;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc          <= RESET_PC;
            outstanding <= 2'd0;
            drop_cnt    <= 2'd0;
            q_cnt       <= 2'd0;
            q_head      <= 1'b0;
            q_tail      <= 1'b0;
            fl_wr       <= 1'b0;
            fl_rd       <= 1'b0;
        end else begin
            fl_wr       <= fl_wr ^ fire;
            fl_rd       <= fl_rd ^ resp_ok;
            outstanding <= outstanding + {1'b0, fire} - {1'b0, resp_ok};
            if (redirect_valid) begin
                // every response still owed to memory belongs to the squashed path
                pc       <= redirect_pc;
                drop_cnt <= outstanding - {1'b0, resp_ok};
                q_cnt    <= 2'd0;
                q_head   <= 1'b0;
                q_tail   <= 1'b0;
            end else begin
                if (fire)
                    pc <= pc + 64'd4;
                if (drop)
                    drop_cnt <= drop_cnt - 2'd1;
                q_tail <= q_tail ^ enq;
                q_head <= q_head ^ deq;
                q_cnt  <= q_cnt + {1'b0, enq} - {1'b0, deq};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (fire)
            fl_pc[fl_wr] <= pc;
        if (enq) begin
            q_pc[q_tail]   <= fl_pc[fl_rd];
            q_inst[q_tail] <= imem_resp_data;
        end
    end

`ifdef IF_PERF_CNT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_fetch_cnt <= 32'd0;
            perf_drop_cnt  <= 32'd0;
        end else begin
            perf_fetch_cnt <= perf_fetch_cnt + {31'd0, deq && !redirect_valid};
            perf_drop_cnt  <= perf_drop_cnt + {31'd0, drop} + (redirect_valid ? {30'd0, q_cnt} : 32'd0);
        end
    end
`endif

    resp_without_request: assert property (@(posedge clk) disable iff (!reset)
        !(imem_resp_valid && outstanding == 2'd0))
        else $error("imem response with no outstanding request");
endmodule

// File: tb/tb_pipeline_if_stage.sv
// tb_pipeline_if_stage: directed vector table plus hand-written redirect/reset sequences.
module tb_pipeline_if_stage;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req_valid, imem_req_ready;
    logic [63:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        stall_ID, valid_ID;
    logic [31:0] instruction_ID;
    logic [63:0] pc_ID;

    pipeline_if_stage dut (
        .clk(clk), .reset(reset),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
        .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .stall_ID(stall_ID),
        .valid_ID(valid_ID), .instruction_ID(instruction_ID), .pc_ID(pc_ID)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] addr;
        int          due;
    } req_t;

    typedef struct {
        logic        rdy, stl, rd;
        logic [63:0] rpc;
        logic        e_req;
        logic [63:0] e_addr;
        logic        e_vid;
        logic [63:0] e_pc;
    } vec_t;

    req_t        pend[$];
    vec_t        vq[$];
    int          cyc, lat, total, bad;
    logic        s_req, s_vid;
    logic [63:0] s_addr, s_pc;
    logic [31:0] s_inst;

    function automatic logic [31:0] inst_of(input logic [63:0] a);
        return a[31:0] ^ 32'h5A5A_0003;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, act, exp);
        end
    endtask

    task automatic add(input logic rdy, input logic stl, input logic rd, input logic [63:0] rpc,
                       input logic er, input logic [63:0] ea, input logic ev, input logic [63:0] ep);
        vq.push_back('{rdy: rdy, stl: stl, rd: rd, rpc: rpc, e_req: er, e_addr: ea, e_vid: ev, e_pc: ep});
    endtask

    // One clock cycle: drive inputs (memory model answers due requests), sample at negedge.
    task automatic cycle(input logic rdy, input logic stl, input logic rd, input logic [63:0] rpc);
        imem_req_ready  = rdy;
        stall_ID        = stl;
        redirect_valid  = rd;
        redirect_pc     = rpc;
        imem_resp_valid = 1'b0;
        imem_resp_data  = 32'd0;
        if (pend.size() > 0 && pend[0].due == cyc) begin
            imem_resp_valid = 1'b1;
            imem_resp_data  = inst_of(pend[0].addr);
            void'(pend.pop_front());
        end
        @(negedge clk);
        s_req  = imem_req_valid;
        s_addr = imem_req_addr;
        s_vid  = valid_ID;
        s_pc   = pc_ID;
        s_inst = instruction_ID;
        if (imem_req_valid && imem_req_ready)
            pend.push_back('{addr: imem_req_addr, due: cyc + lat});
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        reset           = 1'b0;
        imem_req_ready  = 1'b0;
        imem_resp_valid = 1'b0;
        imem_resp_data  = 32'd0;
        redirect_valid  = 1'b0;
        redirect_pc     = 64'd0;
        stall_ID        = 1'b0;
        pend.delete();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        cyc   = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        int found;
        total = 0;
        bad   = 0;
        lat   = 1;
        // rdy stl rd rpc | req addr vid pc_ID   (memory latency 1)
        add(1'b1, 1'b0, 1'b0, 64'h0,   1'b1, 64'h00,  1'b0, 64'h00);
        add(1'b1, 1'b0, 1'b0, 64'h0,   1'b1, 64'h04,  1'b0, 64'h00);
        add(1'b1, 1'b0, 1'b0, 64'h0,   1'b1, 64'h08,  1'b1, 64'h00);
        add(1'b1, 1'b0, 1'b0, 64'h0,   1'b1, 64'h0c,  1'b1, 64'h04);
        add(1'b1, 1'b1, 1'b0, 64'h0,   1'b0, 64'h10,  1'b1, 64'h08);
        add(1'b1, 1'b1, 1'b0, 64'h0,   1'b0, 64'h10,  1'b1, 64'h08);
        add(1'b1, 1'b1, 1'b0, 64'h0,   1'b0, 64'h10,  1'b1, 64'h08);
        add(1'b1, 1'b1, 1'b0, 64'h0,   1'b0, 64'h10,  1'b1, 64'h08);
        add(1'b1, 1'b1, 1'b0, 64'h0,   1'b0, 64'h10,  1'b1, 64'h08);
        add(1'b1, 1'b0, 1'b0, 64'h0,   1'b1, 64'h10,  1'b1, 64'h08);
        add(1'b1, 1'b0, 1'b0, 64'h0,   1'b1, 64'h14,  1'b1, 64'h0c);
        add(1'b0, 1'b0, 1'b0, 64'h0,   1'b1, 64'h18,  1'b1, 64'h10);
        add(1'b0, 1'b0, 1'b0, 64'h0,   1'b1, 64'h18,  1'b1, 64'h14);
        add(1'b1, 1'b0, 1'b0, 64'h0,   1'b1, 64'h18,  1'b0, 64'h00);
        add(1'b1, 1'b0, 1'b0, 64'h0,   1'b1, 64'h1c,  1'b0, 64'h00);
        add(1'b1, 1'b0, 1'b0, 64'h0,   1'b1, 64'h20,  1'b1, 64'h18);
        add(1'b1, 1'b1, 1'b1, 64'h100, 1'b0, 64'h24,  1'b1, 64'h1c);
        add(1'b1, 1'b0, 1'b0, 64'h0,   1'b1, 64'h100, 1'b0, 64'h00);
        add(1'b1, 1'b0, 1'b0, 64'h0,   1'b1, 64'h104, 1'b0, 64'h00);
        add(1'b1, 1'b0, 1'b0, 64'h0,   1'b1, 64'h108, 1'b1, 64'h100);

        reset = 1'b0;
        #1;
        chk("rst_vid", 64'(valid_ID), 64'd0);
        chk("rst_inst", 64'(instruction_ID), 64'(NOP));
        chk("rst_pc", pc_ID, 64'd0);
        chk("rst_addr", imem_req_addr, 64'd0);
        do_reset();

        foreach (vq[i]) begin
            cycle(vq[i].rdy, vq[i].stl, vq[i].rd, vq[i].rpc);
            chk($sformatf("v%0d.req", i), 64'(s_req), 64'(vq[i].e_req));
            chk($sformatf("v%0d.addr", i), s_addr, vq[i].e_addr);
            chk($sformatf("v%0d.vid", i), 64'(s_vid), 64'(vq[i].e_vid));
            chk($sformatf("v%0d.pc", i), s_pc, vq[i].e_pc);
            chk($sformatf("v%0d.inst", i), 64'(s_inst), 64'(vq[i].e_vid ? inst_of(vq[i].e_pc) : NOP));
        end

        // Redirect while two requests are outstanding (latency 3): both responses dropped.
        do_reset();
        lat = 3;
        cycle(1'b1, 1'b0, 1'b0, 64'h0);
        cycle(1'b1, 1'b0, 1'b0, 64'h0);
        cycle(1'b1, 1'b0, 1'b1, 64'h100);
        chk("redir_req_blocked", 64'(s_req), 64'd0);
        cycle(1'b1, 1'b0, 1'b0, 64'h0);
        chk("redir_addr", s_addr, 64'h100);
        chk("redir_vid", 64'(s_vid), 64'd0);
        found = 0;
        for (int k = 0; k < 20 && found == 0; k++) begin
            cycle(1'b1, 1'b0, 1'b0, 64'h0);
            if (s_vid) begin
                found = 1;
                chk("redir_first_pc", s_pc, 64'h100);
                chk("redir_first_inst", 64'(s_inst), 64'(inst_of(64'h100)));
            end
        end
        chk("redir_seen", 64'(found), 64'd1);

        // Asynchronous reset mid-cycle with two requests outstanding.
        do_reset();
        lat = 3;
        cycle(1'b1, 1'b0, 1'b0, 64'h0);
        cycle(1'b1, 1'b0, 1'b0, 64'h0);
        imem_resp_valid = 1'b0;
        #1;
        chk("pre_rst_req", 64'(imem_req_valid), 64'd0);
        chk("pre_rst_addr", imem_req_addr, 64'h08);
        #1;
        reset = 1'b0;
        #1;
        chk("mid_rst_req", 64'(imem_req_valid), 64'd1);
        chk("mid_rst_addr", imem_req_addr, 64'd0);
        chk("mid_rst_vid", 64'(valid_ID), 64'd0);
        chk("mid_rst_inst", 64'(instruction_ID), 64'(NOP));
        chk("mid_rst_pc", pc_ID, 64'd0);
        do_reset();
        lat = 1;
        cycle(1'b1, 1'b0, 1'b0, 64'h0);
        chk("restart_req", 64'(s_req), 64'd1);
        chk("restart_addr", s_addr, 64'd0);
        cycle(1'b1, 1'b0, 1'b0, 64'h0);
        cycle(1'b1, 1'b0, 1'b0, 64'h0);
        chk("restart_vid", 64'(s_vid), 64'd1);
        chk("restart_pc0", s_pc, 64'd0);
        cycle(1'b1, 1'b0, 1'b0, 64'h0);
        chk("restart_pc1", s_pc, 64'd4);
        chk("restart_inst1", 64'(s_inst), 64'(inst_of(64'd4)));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
